// File: rtl/axi_slave_ram.sv
// AXI4 slave backed by a single DEPTH x DATA_W word array.
// Independent write and read FSMs; INCR bursts of full-width beats, wrapping modulo DEPTH.
module axi_slave_ram #(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 512,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned BB     = $clog2(STRB_W);
  localparam int unsigned DW     = $clog2(DEPTH);

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  // Any address bit above the word-index field marks the burst as out of range.
  function automatic logic addr_oob(input logic [ADDR_W-1:0] a);
    return |(a >> (BB + DW));
  endfunction

  function automatic logic [DW-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return DW'(a >> BB);
  endfunction

  // Write channel
  w_state_e        w_state_q, w_state_d;
  logic [ID_W-1:0] w_id_q, w_id_d;
  logic [7:0]      w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [DW-1:0]   w_idx_q, w_idx_d;
  logic            w_oob_q, w_oob_d, w_err_q, w_err_d;
  logic            mem_we;

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_idx_d   = w_idx_q;
    w_oob_d   = w_oob_q;
    w_err_d   = w_err_q;
    mem_we    = 1'b0;
    case (w_state_q)
      WIdle: begin
        if (s_axi_awvalid && s_axi_awready) begin
          w_id_d    = s_axi_awid;
          w_len_d   = s_axi_awlen;
          w_cnt_d   = 8'd0;
          w_idx_d   = addr_idx(s_axi_awaddr);
          w_oob_d   = addr_oob(s_axi_awaddr);
          w_err_d   = addr_oob(s_axi_awaddr);
          w_state_d = WData;
        end
      end
      WData: begin
        if (s_axi_wvalid && s_axi_wready) begin
          mem_we  = !w_oob_q;
          w_idx_d = w_idx_q + DW'(1);
          w_cnt_d = w_cnt_q + 8'd1;
          // Beat count terminates the burst; wlast is only checked against it.
          if (s_axi_wlast != (w_cnt_q == w_len_q)) w_err_d = 1'b1;
          if (w_cnt_q == w_len_q) w_state_d = WResp;
        end
      end
      WResp: begin
        if (s_axi_bvalid && s_axi_bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= WIdle;
      w_id_q    <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_idx_q   <= '0;
      w_oob_q   <= 1'b0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_idx_q   <= w_idx_d;
      w_oob_q   <= w_oob_d;
      w_err_q   <= w_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  assign s_axi_awready = !rst && (w_state_q == WIdle);
  assign s_axi_wready  = !rst && (w_state_q == WData);
  assign s_axi_bvalid  = !rst && (w_state_q == WResp);
  assign s_axi_bid     = s_axi_bvalid ? w_id_q : '0;
  assign s_axi_bresp   = s_axi_bvalid ? {w_err_q, 1'b0} : 2'b00;

  // Read channel
  r_state_e        r_state_q, r_state_d;
  logic [ID_W-1:0] r_id_q, r_id_d;
  logic [7:0]      r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic [DW-1:0]   r_idx_q, r_idx_d, r_fetch_idx;
  logic            r_oob_q, r_oob_d, r_last_q, r_last_d;
  logic            r_load, r_fetch_oob;
  logic [DATA_W-1:0] r_data_q;

  always_comb begin
    r_state_d   = r_state_q;
    r_id_d      = r_id_q;
    r_len_d     = r_len_q;
    r_cnt_d     = r_cnt_q;
    r_idx_d     = r_idx_q;
    r_oob_d     = r_oob_q;
    r_last_d    = r_last_q;
    r_load      = 1'b0;
    r_fetch_idx = r_idx_q;
    r_fetch_oob = r_oob_q;
    case (r_state_q)
      RIdle: begin
        if (s_axi_arvalid && s_axi_arready) begin
          r_id_d      = s_axi_arid;
          r_len_d     = s_axi_arlen;
          r_cnt_d     = 8'd0;
          r_idx_d     = addr_idx(s_axi_araddr);
          r_oob_d     = addr_oob(s_axi_araddr);
          r_last_d    = (s_axi_arlen == 8'd0);
          r_load      = 1'b1;
          r_fetch_idx = addr_idx(s_axi_araddr);
          r_fetch_oob = addr_oob(s_axi_araddr);
          r_state_d   = RData;
        end
      end
      RData: begin
        if (s_axi_rvalid && s_axi_rready) begin
          if (r_last_q) begin
            r_last_d  = 1'b0;
            r_state_d = RIdle;
          end else begin
            r_idx_d     = r_idx_q + DW'(1);
            r_cnt_d     = r_cnt_q + 8'd1;
            r_last_d    = ((r_cnt_q + 8'd1) == r_len_q);
            r_load      = 1'b1;
            r_fetch_idx = r_idx_q + DW'(1);
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  // Registered fetch sees the array before any same-cycle write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= RIdle;
      r_id_q    <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_idx_q   <= '0;
      r_oob_q   <= 1'b0;
      r_last_q  <= 1'b0;
      r_data_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_idx_q   <= r_idx_d;
      r_oob_q   <= r_oob_d;
      r_last_q  <= r_last_d;
      if (r_load) r_data_q <= r_fetch_oob ? '0 : mem[r_fetch_idx];
    end
  end

  assign s_axi_arready = !rst && (r_state_q == RIdle);
  assign s_axi_rvalid  = !rst && (r_state_q == RData);
  assign s_axi_rid     = s_axi_rvalid ? r_id_q : '0;
  assign s_axi_rresp   = s_axi_rvalid ? {r_oob_q, 1'b0} : 2'b00;
  assign s_axi_rlast   = s_axi_rvalid && r_last_q;
  assign s_axi_rdata   = r_data_q;

endmodule

// File: tb/tb_axi_slave_ram.sv
// Directed self-checking bench for axi_slave_ram at default parameters.
module tb_axi_slave_ram;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   awid, bid, arid, rid;
  logic [31:0]  awaddr, araddr;
  logic [7:0]   awlen, arlen;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic [511:0] wdata, rdata;
  logic [63:0]  wstrb;
  logic [1:0]   bresp, rresp;

  int checks = 0;
  int errors = 0;
  logic [511:0] exp_data [0:7];
  logic [511:0] pat;

  localparam logic [63:0] STRB_ALL = {64{1'b1}};

  always #5 clk = ~clk;

  axi_slave_ram dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // lastmode: 0 correct wlast, 1 wlast never asserted, 2 wlast only on first beat
  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [511:0] base, input logic [63:0] strb, input int lastmode,
                             input logic [1:0] exp_resp, input string tag);
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
    check({tag, " awready"}, awready, 1'b1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1;
      wdata  = base + 512'(i);
      wstrb  = strb;
      wlast  = (lastmode == 0) ? (i == int'(len)) : (lastmode == 2) ? (i == 0) : 1'b0;
      check($sformatf("%s wready beat%0d", tag, i), wready, 1'b1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    check({tag, " bvalid"}, bvalid, 1'b1);
    check({tag, " bresp"}, bresp, exp_resp);
    check({tag, " bid"}, bid, id);
    @(posedge clk); #1;
    check({tag, " bvalid held"}, bvalid, 1'b1);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check({tag, " bvalid clear"}, bvalid, 1'b0);
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] exp_resp, input string tag);
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
    check({tag, " arready"}, arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready  = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      check($sformatf("%s rvalid beat%0d", tag, i), rvalid, 1'b1);
      check($sformatf("%s rdata beat%0d", tag, i), rdata, exp_data[i]);
      check($sformatf("%s rlast beat%0d", tag, i), rlast, i == int'(len));
      check($sformatf("%s rresp beat%0d", tag, i), rresp, exp_resp);
      check($sformatf("%s rid beat%0d", tag, i), rid, id);
      @(posedge clk); #1;
    end
    rready = 1'b0;
    check({tag, " rvalid clear"}, rvalid, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst awready", awready, 1'b0);
    check("rst arready", arready, 1'b0);
    check("rst wready", wready, 1'b0);
    check("rst bvalid", bvalid, 1'b0);
    check("rst rvalid", rvalid, 1'b0);
    check("rst rdata", rdata, 512'd0);
    rst = 1'b0;
    #1;

    // 4-beat burst at word 1
    write_burst(4'h3, 32'h40, 8'd3, 512'd1, STRB_ALL, 0, 2'b00, "wr_basic");
    for (int i = 0; i < 4; i++) exp_data[i] = 512'(i + 1);
    read_burst(4'h5, 32'h40, 8'd3, 2'b00, "rd_basic");

    // Partial strobes on word 5, then an all-zero-strobe beat
    write_burst(4'h1, 32'h140, 8'd0, {512{1'b1}}, STRB_ALL, 0, 2'b00, "wr_ones");
    write_burst(4'h2, 32'h140, 8'd0, {480'd0, 32'hA5A5_A5A5}, 64'hF, 0, 2'b00, "wr_strb");
    write_burst(4'h2, 32'h140, 8'd0, 512'd0, 64'd0, 0, 2'b00, "wr_nostrb");
    exp_data[0] = {{480{1'b1}}, 32'hA5A5_A5A5};
    read_burst(4'h6, 32'h140, 8'd0, 2'b00, "rd_strb");

    // Wrap from word 254 through 255, 0, 1
    write_burst(4'h4, 32'h3F80, 8'd3, 512'h100, STRB_ALL, 0, 2'b00, "wr_wrap");
    for (int i = 0; i < 4; i++) exp_data[i] = 512'h100 + 512'(i);
    read_burst(4'h4, 32'h3F80, 8'd3, 2'b00, "rd_wrap");
    exp_data[0] = 512'h102;
    read_burst(4'h4, 32'h0, 8'd0, 2'b00, "rd_word0");

    // wlast missing on last beat, then early wlast: SLVERR but data written
    write_burst(4'h8, 32'h280, 8'd1, 512'h200, STRB_ALL, 1, 2'b10, "wr_nolast");
    exp_data[0] = 512'h200; exp_data[1] = 512'h201;
    read_burst(4'h8, 32'h280, 8'd1, 2'b00, "rd_nolast");
    write_burst(4'h9, 32'h2C0, 8'd1, 512'h300, STRB_ALL, 2, 2'b10, "wr_early");
    exp_data[0] = 512'h300; exp_data[1] = 512'h301;
    read_burst(4'h9, 32'h2C0, 8'd1, 2'b00, "rd_early");

    // Out-of-range start: writes suppressed (words 0,1 unchanged), reads return zero
    write_burst(4'hA, 32'h0001_0000, 8'd1, 512'hDEAD, STRB_ALL, 0, 2'b10, "wr_oob");
    exp_data[0] = 512'h102; exp_data[1] = 512'h103;
    read_burst(4'hA, 32'h0, 8'd1, 2'b00, "rd_after_oob");
    exp_data[0] = 512'd0; exp_data[1] = 512'd0;
    read_burst(4'hB, 32'h0001_0000, 8'd1, 2'b10, "rd_oob");

    // Stalled read from word 2 (rready 1,0,0) then reset with beat 2 pending
    arid = 4'h7; araddr = 32'h80; arlen = 8'd3; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready = 1'b1;
    check("stall beat1 rvalid", rvalid, 1'b1);
    check("stall beat1 rdata", rdata, 512'd2);
    @(posedge clk); #1;
    rready = 1'b0;
    check("stall beat2 rdata", rdata, 512'd3);
    @(posedge clk); #1;
    check("stall hold1 rvalid", rvalid, 1'b1);
    check("stall hold1 rdata", rdata, 512'd3);
    check("stall hold1 rlast", rlast, 1'b0);
    check("stall hold1 rid", rid, 4'h7);
    @(posedge clk); #1;
    check("stall hold2 rdata", rdata, 512'd3);
    rready = 1'b1;
    rst = 1'b1;
    #1;
    check("midrst arready", arready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    rready = 1'b0;
    check("midrst rvalid", rvalid, 1'b0);
    check("midrst rdata", rdata, 512'd0);
    @(posedge clk); #1;
    check("postrst arready", arready, 1'b1);
    check("postrst rvalid", rvalid, 1'b0);
    check("postrst bvalid", bvalid, 1'b0);

    // Memory survives reset
    exp_data[0] = 512'd2;
    read_burst(4'hC, 32'h80, 8'd0, 2'b00, "rd_retain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
